// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential divider.
package div_pkg;

    // Default widths match the Multi3 product (6 bits) and operand (3 bits)
    localparam int DIV_DW = 6;
    localparam int DIV_VW = 3;
    localparam int DIV_CW = $clog2(DIV_DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width for a given dividend width
    function automatic int div_cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step
    import div_pkg::*;
#(
    parameter int VW = DIV_VW
) (
    input  logic [VW:0]   pr,
    input  logic          nbit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   pr_next,
    output logic          q_bit
);

    logic [VW:0] trial;
    logic        ge;

    // Shift and trial-subtract; a set pr MSB means the shifted value already exceeds the divisor
    always_comb begin
        trial   = {pr[VW-1:0], nbit};
        ge      = pr[VW] | (trial >= {1'b0, divisor});
        q_bit   = ge;
        pr_next = ge ? (trial - {1'b0, divisor}) : trial;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, start/done handshake.
// Optional result self-check (quotient*divisor + remainder == dividend) under DIV_CHECK_EN.
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          chk_err
);

    localparam int CW = div_cnt_width(DW);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] n_q;
    logic [DW-1:0] qw_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   pr_q;
    logic [VW:0]   pr_next;
    logic          q_bit;
    logic          last_step;
    logic          dbz;

    assign last_step = (cnt_q == CW'(DW - 1));
    assign dbz       = (dvs_q == '0);
    assign busy      = (state_q != ST_IDLE);

    div_step #(
        .VW(VW)
    ) u_step (
        .pr     (pr_q),
        .nbit   (n_q[DW-1]),
        .divisor(dvs_q),
        .pr_next(pr_next),
        .q_bit  (q_bit)
    );

    // FSM, iteration counter and working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            qw_q    <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_q     <= dividend;
                        dvs_q   <= divisor;
                        pr_q    <= '0;
                        qw_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= (divisor != '0) ? ST_CALC : ST_DONE;
                    end
                end
                ST_CALC: begin
                    pr_q  <= pr_next;
                    qw_q  <= {qw_q[DW-2:0], q_bit};
                    n_q   <= {n_q[DW-2:0], 1'b0};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Result registers: only loaded when leaving DONE, so CALC never disturbs them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                quotient    <= dbz ? '1 : qw_q;
                remainder   <= dbz ? '0 : pr_q[VW-1:0];
                div_by_zero <= dbz;
            end
        end
    end

`ifdef DIV_CHECK_EN
    localparam int PW = DW + VW;

    logic [DW-1:0] dvd_q;
    logic [PW-1:0] acc;
    logic [PW-1:0] addend;
    logic [PW-1:0] sum;
    logic          carry;
    logic          mismatch;
    logic          chk_q;

    // Keep the original dividend; the working copy is shifted away during CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            dvd_q <= dividend;
        end
    end

    // Rebuild quotient*divisor + remainder from and2/xor2/or2 rows of ripple adders
    always_comb begin
        acc    = PW'(pr_q[VW-1:0]);
        addend = '0;
        sum    = '0;
        carry  = 1'b0;
        for (int i = 0; i < DW; i++) begin
            addend = '0;
            for (int j = 0; j < VW; j++) begin
                addend[i+j] = qw_q[i] & dvs_q[j];
            end
            carry = 1'b0;
            for (int b = 0; b < PW; b++) begin
                sum[b] = acc[b] ^ addend[b] ^ carry;
                carry  = (acc[b] & addend[b]) | (carry & (acc[b] ^ addend[b]));
            end
            acc = sum;
        end
        mismatch = (acc != {{VW{1'b0}}, dvd_q});
    end

    // Check flag is registered alongside done and held with the results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            chk_q <= ~dbz & mismatch;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed self-checking bench for seq_divider against a plain arithmetic model.
module tb_seq_divider;

    localparam int DW = 6;
    localparam int VW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          chk_err;

    int n_checks = 0;
    int n_pass   = 0;
    int last_q   = 0;
    int last_r   = 0;

    seq_divider #(
        .DW(DW),
        .VW(VW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention
    function automatic void ref_div(input int a, input int b, output int q, output int r,
                                    output int z, output int lat);
        if (b == 0) begin
            q   = (1 << DW) - 1;
            r   = 0;
            z   = 1;
            lat = 1;
        end else begin
            q   = a / b;
            r   = a % b;
            z   = 0;
            lat = DW + 1;
        end
    endfunction

    // Wait (bounded) for done, counting edges since the accepting edge
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input int a, input int b);
        int q, r, z, el, lat;
        ref_div(a, b, q, r, z, el);
        @(negedge clk);
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        check("busy_after_accept", busy, 1);
        check("result_held", quotient, last_q);
        wait_done(lat);
        check("done_seen", done, 1);
        check("latency", lat, el);
        check("quotient", quotient, q);
        check("remainder", remainder, r);
        check("div_by_zero", div_by_zero, z);
        check("chk_err", chk_err, 0);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse_width", done, 0);
        last_q = q;
        last_r = r;
    endtask

    initial begin
        int lat, pulses, q, r, z, el, a, b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_chk", chk_err, 0);
        rst = 1'b0;

        // Directed cases
        do_op(45, 6);
        do_op(63, 7);
        do_op(0, 5);
        do_op(63, 1);
        do_op(5, 0);
        do_op(45, 6);

        // start pulsed mid-CALC must not disturb the operation in flight
        last_q = 0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 3'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd9;
        divisor  = 3'd2;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                pulses++;
                check("midstart_quotient", quotient, 7);
                check("midstart_remainder", remainder, 3);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("midstart_pulses", pulses, 1);

        // Reset in the middle of CALC aborts the operation
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 3'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        last_q = 0;
        last_r = 0;
        do_op(20, 3);

        // Random operations
        for (int i = 0; i < 20; i++) begin
            do_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
        end

        // Exhaustive sweep, back-to-back with start held high
        @(negedge clk);
        start    = 1'b1;
        dividend = '0;
        divisor  = '0;
        for (int idx = 0; idx < 512; idx++) begin
            a = idx / 8;
            b = idx % 8;
            ref_div(a, b, q, r, z, el);
            @(posedge clk);
            @(negedge clk);
            check("sweep_accept", busy, 1);
            if (idx < 511) begin
                dividend = DW'((idx + 1) / 8);
                divisor  = VW'((idx + 1) % 8);
            end else begin
                start = 1'b0;
            end
            wait_done(lat);
            check("sweep_latency", lat, el);
            check("sweep_quotient", quotient, q);
            check("sweep_remainder", remainder, r);
            check("sweep_dbz", div_by_zero, z);
            check("sweep_chk", chk_err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
